cpu_sram_arbiter: RTL and testbench
===================================

// Module: cpu_sram_arbiter
// PURPOSE
//   Sits directly downstream of mycpu_top's fetch and memory stages.
//   Merges the instruction-fetch and data-access sram-like request ports onto one sram-like slave port.
//   The slave port feeds the SoC bus bridge.
//   One transaction in flight at a time; fixed-priority arbitration; all handshakes are request/addr_ok/data_ok.
// PARAMETERS
//   ADDR_W      32  address width on all ports
//   DATA_FIRST  1   1: data port wins simultaneous requests; 0: inst port wins
// PORTS
//   clk           in   1       core clock; all state on rising edge
//   resetn        in   1       asynchronous, active-low reset
//   inst_req      in   1       fetch request (read only, word size)
//   inst_addr     in   ADDR_W  fetch address
//   inst_addr_ok  out  1       fetch request accepted this cycle
//   inst_data_ok  out  1       fetch data valid this cycle
//   inst_rdata    out  32      fetch data
//   data_req      in   1       load/store request
//   data_wr       in   1       1 = store
//   data_size     in   2       0 byte, 1 half, 2 word
//   data_addr     in   ADDR_W  load/store address
//   data_wdata    in   32      store data
//   data_addr_ok  out  1       load/store accepted this cycle
//   data_data_ok  out  1       load data valid / store complete this cycle
//   data_rdata    out  32      load data
//   m_req         out  1       slave request
//   m_wr          out  1       slave write
//   m_size        out  2       slave size
//   m_addr        out  ADDR_W  slave address
//   m_wdata       out  32      slave write data
//   m_addr_ok     in   1       slave accepted request
//   m_data_ok     in   1       slave response valid
//   m_rdata       in   32      slave read data
// BEHAVIOUR
//   Reset values (resetn=0, async):
//     - state=IDLE; owner=INST.
//     - Latched req fields = 0.
//     - Every output = 0.
//   FSM states:
//     - IDLE: if (data_req|inst_req), grant per DATA_FIRST.
//       Pulse granted *_addr_ok combinationally in this cycle.
//       Latch wr/size/addr/wdata and owner.
//       Inst grants latch wr=0, size=2, wdata=0. Next state REQ.
//     - REQ: m_req=1 with latched fields, held stable until m_addr_ok.
//       On m_addr_ok & ~m_data_ok -> WAIT.
//       On m_addr_ok & m_data_ok (same cycle) -> complete, -> IDLE.
//     - WAIT: m_req=0. On m_data_ok -> complete, -> IDLE.
//   Complete:
//     - Owner's *_data_ok = 1 combinationally in the m_data_ok cycle.
//     - Owner's *_rdata = m_rdata in that cycle, else 0.
//     - Non-owner data_ok/rdata stay 0.
//     - Store completion also pulses data_data_ok, with data_rdata = m_rdata (ignored by core).
//   Latency (zero-wait slave):
//     - Accept in cycle N, m_req in N+1, data_ok in N+1.
//     - Back-to-back throughput is 1 transaction per 2 cycles.
//   Both *_addr_ok are 0 outside IDLE; masters hold req until accepted.
//   A req dropped while not yet accepted is simply never granted.
//   A spurious m_data_ok in IDLE/REQ without m_addr_ok is ignored (no pulse).
//   No alignment check; misalignment is trapped by the core before issue.
//   resetn low mid-transaction: immediate IDLE, in-flight slave txn abandoned (slave shares reset).
// STRUCTURE
//   cpu_bus_pkg holds:
//     - state enum {IDLE, REQ, WAIT}
//     - owner enum {OWN_INST, OWN_DATA}
//     - SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2
//   Single module, no sub-module: one FSM plus a request-latch register.
// TESTING
//   1. Reset: assert resetn=0 mid-WAIT -> all outputs 0 at once, state IDLE; next inst_req accepted normally.
//   2. Lone fetch, addr 0xBFC00000, slave m_rdata 0x3C1D0000, zero-wait -> inst_addr_ok in N.
//      m_req/m_addr=0xBFC00000 in N+1; inst_data_ok, inst_rdata=0x3C1D0000 in N+1.
//   3. Simultaneous inst_req & data_req, DATA_FIRST=1 -> data granted first, inst accepted in the next IDLE.
//      With DATA_FIRST=0, the order is reversed.
//   4. Store, size 0, addr 0x80001003, wdata 0xAB, slave addr_ok after 3 cycles -> m_wr=1, m_size=0.
//      m_addr/m_wdata held stable all 3 cycles; data_data_ok once; inst_data_ok never.
//   5. m_addr_ok in cycle K, m_data_ok in K+4 -> state WAIT for 4 cycles, m_req=0 in WAIT.
//      No addr_ok to either master until after K+4.
//   6. Spurious m_data_ok while IDLE -> no data_ok pulse; owner unchanged.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_pkg
// Description : Shared encodings for the CPU sram-like bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_bus_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t REQ  = 2'd1;
    localparam state_t WAIT = 2'd2;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/cpu_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sram_arbiter
// Description : Merges fetch and load/store sram-like ports onto one slave
//               port; one transaction in flight, fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_sram_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int   ADDR_W     = 32,
    parameter logic DATA_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,

    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [31:0]       m_rdata
);

    state_t              r_state;
    state_t              w_stateNext;
    owner_t              r_owner;
    logic                r_wr;
    logic [1:0]          r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;

    logic                w_idle;
    logic                w_grantData;
    logic                w_grantInst;
    logic                w_complete;
    logic                w_instDone;
    logic                w_dataDone;

    // Accept strobes are combinational, so they are masked by reset to keep
    // every output low while resetn is asserted.
    assign w_idle      = resetn && (r_state == IDLE);
    assign w_grantData = w_idle && data_req && (DATA_FIRST || !inst_req);
    assign w_grantInst = w_idle && inst_req && !w_grantData;

    // A response only counts once the slave has taken the request.
    assign w_complete  = ((r_state == REQ)  && m_addr_ok && m_data_ok) ||
                         ((r_state == WAIT) && m_data_ok);
    assign w_instDone  = w_complete && (r_owner == OWN_INST);
    assign w_dataDone  = w_complete && (r_owner == OWN_DATA);

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (w_grantData || w_grantInst) begin
                    w_stateNext = REQ;
                end
            end
            REQ: begin
                if (m_addr_ok) begin
                    w_stateNext = m_data_ok ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (m_data_ok) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_owner <= OWN_INST;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_stateNext;
            if (w_grantData) begin
                r_owner <= OWN_DATA;
                r_wr    <= data_wr;
                r_size  <= data_size;
                r_addr  <= data_addr;
                r_wdata <= data_wdata;
            end else if (w_grantInst) begin
                r_owner <= OWN_INST;
                r_wr    <= 1'b0;
                r_size  <= SIZE_WORD;
                r_addr  <= inst_addr;
                r_wdata <= 32'd0;
            end
        end
    end

    assign inst_addr_ok = w_grantInst;
    assign data_addr_ok = w_grantData;
    assign inst_data_ok = w_instDone;
    assign data_data_ok = w_dataDone;
    assign inst_rdata   = w_instDone ? m_rdata : 32'd0;
    assign data_rdata   = w_dataDone ? m_rdata : 32'd0;

    assign m_req   = (r_state == REQ);
    assign m_wr    = r_wr;
    assign m_size  = r_size;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_sram_arbiter
// Description : Scoreboard bench for cpu_sram_arbiter with directed cases and
//               randomized masters/slave against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sram_arbiter;

    localparam int   ADDR_W     = 32;
    localparam logic DATA_FIRST = 1'b1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    cpu_sram_arbiter #(.ADDR_W(ADDR_W), .DATA_FIRST(DATA_FIRST)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    int nChecks = 0;
    int nFail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: one outstanding txn, priority grant
    typedef struct {
        bit        own;   // 0 fetch, 1 load/store
        bit        wr;
        bit [1:0]  size;
        bit [31:0] addr;
        bit [31:0] wdata;
    } req_t;

    req_t reqQ[$];
    bit   ownQ[$];
    bit   busy = 1'b0;
    bit   expI, expD, o;
    req_t r;

    // ---------------- slave behaviour / configuration
    int          cfgAddrDly = 0;
    int          cfgDataDly = 0;
    bit          cfgRand    = 1'b0;
    bit          cfgRdFix   = 1'b0;
    bit          cfgSpurNow = 1'b0;
    logic [31:0] cfgRdata   = 32'd0;
    bit          slPend = 1'b0, slArmed = 1'b0, slDataNow = 1'b0;
    int          slCnt = 0, slD = 0;

    initial begin
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            m_addr_ok = 1'b0; m_data_ok = 1'b0; slDataNow = 1'b0;
            m_rdata   = cfgRdFix ? cfgRdata : $urandom;
            if (!resetn) begin
                slPend = 1'b0; slArmed = 1'b0;
            end else if (slPend) begin
                if (slCnt == 0) begin
                    m_data_ok = 1'b1; slDataNow = 1'b1; slPend = 1'b0;
                end else slCnt--;
            end else if (m_req) begin
                if (!slArmed) begin
                    slArmed = 1'b1;
                    slCnt   = cfgRand ? int'($urandom_range(0, 3)) : cfgAddrDly;
                end
                if (slCnt == 0) begin
                    m_addr_ok = 1'b1; slArmed = 1'b0;
                    slD = cfgRand ? int'($urandom_range(0, 3)) : cfgDataDly;
                    if (slD == 0) begin
                        m_data_ok = 1'b1; slDataNow = 1'b1;
                    end else begin
                        slPend = 1'b1; slCnt = slD - 1;
                    end
                end else begin
                    slCnt--;
                    if (cfgRand && $urandom_range(0, 7) == 0) m_data_ok = 1'b1;
                end
            end else if (cfgSpurNow || (cfgRand && $urandom_range(0, 7) == 0)) begin
                m_data_ok = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard
    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_outputs_zero", |{inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok,
                data_data_ok, data_rdata, m_req, m_wr, m_size, m_addr, m_wdata}, 0);
            reqQ.delete(); ownQ.delete(); busy = 1'b0;
        end else begin
            expD = !busy && data_req && (DATA_FIRST || !inst_req);
            expI = !busy && inst_req && !expD;
            chk("inst_addr_ok", inst_addr_ok, expI);
            chk("data_addr_ok", data_addr_ok, expD);
            chk("m_req", m_req, reqQ.size() != 0);
            if (m_req && reqQ.size() != 0) begin
                r = reqQ[0];
                chk("m_addr", m_addr, r.addr);
                chk("m_wr", m_wr, r.wr);
                chk("m_size", m_size, r.size);
                chk("m_wdata", m_wdata, r.wdata);
                if (m_addr_ok) begin
                    ownQ.push_back(r.own);
                    r = reqQ.pop_front();
                end
            end
            if (slDataNow) begin
                chk("resp_outstanding", ownQ.size() != 0, 1);
                if (ownQ.size() != 0) begin
                    o = ownQ.pop_front();
                    chk("inst_data_ok", inst_data_ok, !o);
                    chk("data_data_ok", data_data_ok, o);
                    chk("inst_rdata", inst_rdata, o ? 32'd0 : m_rdata);
                    chk("data_rdata", data_rdata, o ? m_rdata : 32'd0);
                    busy = 1'b0;
                end
            end else begin
                chk("inst_data_ok_idle", inst_data_ok, 0);
                chk("data_data_ok_idle", data_data_ok, 0);
                chk("inst_rdata_idle", inst_rdata, 0);
                chk("data_rdata_idle", data_rdata, 0);
            end
            if (expI) begin
                reqQ.push_back('{own: 1'b0, wr: 1'b0, size: 2'd2, addr: inst_addr, wdata: 32'd0});
                busy = 1'b1;
            end
            if (expD) begin
                reqQ.push_back('{own: 1'b1, wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata});
                busy = 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    int  reqCyc, dOk, iOk, dOff, aOff, waitLow;
    bit  wrOk, iAcc, dAcc;

    initial begin
        resetn = 1'b0; inst_req = 1'b0; inst_addr = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
        repeat (3) @(negedge clk);
        cyc(); resetn = 1'b1;
        cyc();

        // lone fetch, zero-wait slave
        cfgRdFix = 1'b1; cfgRdata = 32'h3C1D_0000; cfgAddrDly = 0; cfgDataDly = 0;
        cyc(); inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        @(negedge clk); chk("t2_addr_ok_N", inst_addr_ok, 1);
        cyc(); inst_req = 1'b0;
        @(negedge clk);
        chk("t2_m_req_N1", m_req, 1);
        chk("t2_m_addr_N1", m_addr, 32'hBFC0_0000);
        chk("t2_data_ok_N1", inst_data_ok, 1);
        chk("t2_rdata_N1", inst_rdata, 32'h3C1D_0000);
        cfgRdFix = 1'b0;

        // simultaneous requests
        cyc(); inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0010;
        @(negedge clk);
        chk("t3_first_inst", inst_addr_ok, !DATA_FIRST);
        chk("t3_first_data", data_addr_ok, DATA_FIRST);
        cyc(); if (DATA_FIRST) data_req = 1'b0; else inst_req = 1'b0;
        @(negedge clk);
        chk("t3_busy_inst", inst_addr_ok, 0);
        chk("t3_busy_data", data_addr_ok, 0);
        @(negedge clk);
        chk("t3_second_inst", inst_addr_ok, DATA_FIRST);
        chk("t3_second_data", data_addr_ok, !DATA_FIRST);
        cyc(); inst_req = 1'b0; data_req = 1'b0;
        cyc(); cyc();

        // byte store with slow slave accept
        cfgAddrDly = 3; cfgDataDly = 0;
        cyc(); data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
        data_addr = 32'h8000_1003; data_wdata = 32'h0000_00AB;
        @(negedge clk); chk("t4_addr_ok", data_addr_ok, 1);
        cyc(); data_req = 1'b0;
        reqCyc = 0; dOk = 0; iOk = 0; wrOk = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_req) begin
                reqCyc++;
                if (!(m_wr && m_size == 2'd0 && m_addr == 32'h8000_1003 && m_wdata == 32'hAB)) wrOk = 1'b0;
            end
            dOk += int'(data_data_ok);
            iOk += int'(inst_data_ok);
        end
        chk("t4_req_cycles", reqCyc, 4);
        chk("t4_fields_stable", wrOk, 1);
        chk("t4_data_ok_once", dOk, 1);
        chk("t4_inst_ok_never", iOk, 0);
        cfgAddrDly = 0;

        // long WAIT: data_ok four cycles after accept, pending load blocked
        cfgDataDly = 4;
        cyc(); inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
        @(negedge clk);
        cyc(); inst_req = 1'b0; data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0040;
        @(negedge clk); chk("t5_accept_K", m_req & m_addr_ok, 1);
        dOff = -1; aOff = -1; waitLow = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (inst_data_ok && dOff < 0) dOff = i;
            if (i <= 4 && !m_req) waitLow++;
            if (data_addr_ok && aOff < 0) aOff = i;
            if (aOff >= 0) break;
        end
        cfgDataDly = 0;
        chk("t5_data_ok_offset", dOff, 4);
        chk("t5_m_req_low_in_wait", waitLow, 4);
        chk("t5_next_accept_offset", aOff, 5);
        cyc(); data_req = 1'b0;
        repeat (3) cyc();

        // spurious slave response while idle
        @(negedge clk); cfgSpurNow = 1'b1;
        @(posedge clk); #2;
        cfgSpurNow = 1'b0;
        @(negedge clk);
        chk("t6_inst_ok_spur", inst_data_ok, 0);
        chk("t6_data_ok_spur", data_data_ok, 0);
        cyc(); inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
        @(negedge clk); chk("t6_fetch_after", inst_addr_ok, 1);
        cyc(); inst_req = 1'b0;
        repeat (2) cyc();

        // reset in the middle of WAIT
        cfgDataDly = 5;
        cyc(); inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
        @(negedge clk);
        cyc(); inst_req = 1'b0;
        cyc(); cyc();
        #1 resetn = 1'b0;
        #1 chk("t1_async_outputs_zero", |{inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok,
               data_data_ok, data_rdata, m_req, m_wr, m_size, m_addr, m_wdata}, 0);
        cyc(); cyc(); resetn = 1'b1; cfgDataDly = 0;
        cyc(); inst_req = 1'b1; inst_addr = 32'hBFC0_0300;
        @(negedge clk); chk("t1_accept_after_reset", inst_addr_ok, 1);
        cyc(); inst_req = 1'b0;
        repeat (2) cyc();

        // randomized traffic
        cfgRand = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk); iAcc = inst_addr_ok; dAcc = data_addr_ok;
            cyc();
            if (!inst_req || iAcc) begin
                inst_req  = ($urandom_range(0, 3) != 0);
                inst_addr = $urandom & 32'hFFFF_FFFC;
            end else if ($urandom_range(0, 15) == 0) inst_req = 1'b0;
            if (!data_req || dAcc) begin
                data_req   = ($urandom_range(0, 2) != 0);
                data_wr    = 1'($urandom_range(0, 1));
                data_size  = 2'($urandom_range(0, 2));
                data_addr  = $urandom;
                data_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) data_req = 1'b0;
        end
        inst_req = 1'b0; data_req = 1'b0;
        repeat (30) cyc();
        chk("drain_empty", reqQ.size() + ownQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
